// File: rtl/ccip_rd_arbiter.sv
// ccip_rd_arbiter
// ---------------
// Round-robin arbiter that lets NUM_REQ engine instances share one CCI-P
// c0 read-request channel. The winner's index goes into the mdata tag bits of
// its request. Each read response is routed back by decoding that tag. Every
// requester has a credit counter of outstanding reads, capped at
// MAX_OUTSTANDING. Dropping enable stops new grants; idle then rises once all
// outstanding reads have returned, so the job can be torn down cleanly.
//
// Ports:
//   clk             clock
//   reset           asynchronous reset, active low
//   enable          1 = accept and issue requests, 0 = drain
//   req_valid       per-requester header-ready flags
//   req_hdr         per-requester headers, requester i at [i*HDR_WIDTH +: HDR_WIDTH]
//   req_ready       one-hot pop strobe (combinational)
//   tx_valid        registered c0 Tx request valid
//   tx_hdr          registered c0 Tx header with the tag inserted
//   tx_alm_full     shell c0TxAlmFull
//   rsp_valid       shell c0 Rx response valid
//   rsp_hdr         shell c0 Rx response header
//   rsp_sel         registered one-hot response route
//   outstanding_cnt per-requester outstanding-read counters, CNT_BITS each
//   idle            FSM idle and no reads outstanding
//   err_underflow   sticky: a response arrived with no matching outstanding read
module ccip_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_BITS         = 2,
  parameter int TAG_LSB         = 14,
  parameter int HDR_WIDTH       = 74,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_BITS        = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*HDR_WIDTH-1:0]  req_hdr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [HDR_WIDTH-1:0]          tx_hdr,
  input  logic                          tx_alm_full,
  input  logic                          rsp_valid,
  input  logic [HDR_WIDTH-1:0]          rsp_hdr,
  output logic [NUM_REQ-1:0]            rsp_sel,
  output logic [NUM_REQ*CNT_BITS-1:0]   outstanding_cnt,
  output logic                          idle,
  output logic                          err_underflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ID_BITS-1:0]   rr_ptr_r;
  logic [CNT_BITS-1:0]  cnt_r [NUM_REQ];
  logic                 tx_valid_r;
  logic [HDR_WIDTH-1:0] tx_hdr_r;
  logic [NUM_REQ-1:0]   rsp_sel_r;
  logic                 err_underflow_r;

  logic [NUM_REQ-1:0]   elig_s;
  logic [NUM_REQ-1:0]   nz_s;
  logic [NUM_REQ-1:0]   inc_s;
  logic [NUM_REQ-1:0]   dec_s;
  logic                 all_zero_s;
  logic                 grant_vld_s;
  logic [ID_BITS-1:0]   grant_idx_s;
  logic [ID_BITS-1:0]   cand_s;
  logic [HDR_WIDTH-1:0] tagged_hdr_s;
  logic [ID_BITS-1:0]   rsp_tag_s;
  logic                 rsp_tag_ok_s;
  logic                 underflow_s;
  logic                 rsp_hdr_unused_s;

  // Only the tag field of the response header matters here.
  assign rsp_hdr_unused_s = ^rsp_hdr;

  assign rsp_tag_s    = rsp_hdr[TAG_LSB +: ID_BITS];
  assign rsp_tag_ok_s = (int'(rsp_tag_s) < NUM_REQ);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign nz_s[i]   = (cnt_r[i] != '0);
    assign elig_s[i] = (state_r == ST_RUN) && !tx_alm_full && req_valid[i] &&
                       (cnt_r[i] < CNT_BITS'(MAX_OUTSTANDING));
    assign inc_s[i]  = grant_vld_s && (grant_idx_s == ID_BITS'(i));
    assign dec_s[i]  = rsp_valid && rsp_tag_ok_s && (rsp_tag_s == ID_BITS'(i));
    assign outstanding_cnt[i*CNT_BITS +: CNT_BITS] = cnt_r[i];

    // Outstanding-read counter; a grant and a response in the same cycle
    // cancel, and a response at zero leaves the counter at zero.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_r[i] <= '0;
      end else if (inc_s[i] && !dec_s[i]) begin
        cnt_r[i] <= cnt_r[i] + CNT_BITS'(1);
      end else if (dec_s[i] && !inc_s[i] && nz_s[i]) begin
        cnt_r[i] <= cnt_r[i] - CNT_BITS'(1);
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  assign all_zero_s  = ~|nz_s;
  // Unknown tags, and responses to a requester with nothing outstanding.
  assign underflow_s = rsp_valid && (!rsp_tag_ok_s || (|(dec_s & ~nz_s)));
  assign req_ready   = inc_s;

  // Round-robin search starting one past the last winner.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = ID_BITS'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!grant_vld_s && elig_s[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Winner's header with its index written into the mdata tag field.
  always_comb begin
    tagged_hdr_s = req_hdr[int'(grant_idx_s)*HDR_WIDTH +: HDR_WIDTH];
    tagged_hdr_s[TAG_LSB +: ID_BITS] = grant_idx_s;
  end

  // Enable/drain sequencing; a returning enable cancels a drain.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_nxt_s = ST_RUN;
        else        state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable) state_nxt_s = ST_DRAIN;
        else         state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (enable)          state_nxt_s = ST_RUN;
        else if (all_zero_s) state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Round-robin pointer; moves only when a grant is made.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           rr_ptr_r <= ID_BITS'(NUM_REQ - 1);
    else if (grant_vld_s) rr_ptr_r <= grant_idx_s;
    else                  rr_ptr_r <= rr_ptr_r;
  end

  // Request output register; the header holds when nothing is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid_r <= 1'b0;
      tx_hdr_r   <= '0;
    end else if (grant_vld_s) begin
      tx_valid_r <= 1'b1;
      tx_hdr_r   <= tagged_hdr_s;
    end else begin
      tx_valid_r <= 1'b0;
      tx_hdr_r   <= tx_hdr_r;
    end
  end

  // Response route and sticky underflow flag; responses are accepted in any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_sel_r       <= '0;
      err_underflow_r <= 1'b0;
    end else begin
      rsp_sel_r       <= dec_s;
      err_underflow_r <= err_underflow_r | underflow_s;
    end
  end

  assign tx_valid      = tx_valid_r;
  assign tx_hdr        = tx_hdr_r;
  assign rsp_sel       = rsp_sel_r;
  assign err_underflow = err_underflow_r;
  assign idle          = (state_r == ST_IDLE) && all_zero_s;

endmodule
